// File: rtl/bcd_count_sequencer.sv
// Multi-digit BCD counter: CLEAR/LOAD complete in one edge, UP/DOWN ripple one digit per cycle.
// Define BCD_SATURATE_EN to hold the count at the limits instead of wrapping.
module bcd_count_sequencer #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                done,
    output logic                wrap
);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic {IDLE, STEP} state_t;
    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_LOAD  = 2'b11
    } op_t;

    state_t              state, state_nx;
    logic [4*DIGITS-1:0] cnt_q, cnt_nx;
    logic [IW-1:0]       idx, idx_nx;
    logic                dir_up, dir_up_nx;
    logic                done_nx, wrap_nx;
    logic [3:0]          cur_digit, new_digit;
    logic                carry;

    // Single shared digit unit, steered by the ripple index.
    always_comb begin
        cur_digit = cnt_q[{idx, 2'b00} +: 4];
        if (dir_up) begin
            carry     = (cur_digit == 4'd9);
            new_digit = carry ? 4'd0 : cur_digit + 4'd1;
        end else begin
            carry     = (cur_digit == 4'd0);
            new_digit = carry ? 4'd9 : cur_digit - 4'd1;
        end
    end

`ifdef BCD_SATURATE_EN
    logic all_nine, all_zero;
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (cnt_q[4*d +: 4] != 4'd9) all_nine = 1'b0;
            if (cnt_q[4*d +: 4] != 4'd0) all_zero = 1'b0;
        end
    end
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_q;
        idx_nx    = idx;
        dir_up_nx = dir_up;
        done_nx   = 1'b0;
        wrap_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            cnt_nx  = '0;
                            done_nx = 1'b1;
                        end
                        OP_LOAD: begin
                            for (int unsigned d = 0; d < DIGITS; d++) begin
                                cnt_nx[4*d +: 4] = (load_value[4*d +: 4] > 4'd9) ? 4'd0
                                                                                 : load_value[4*d +: 4];
                            end
                            done_nx = 1'b1;
                        end
                        default: begin
`ifdef BCD_SATURATE_EN
                            if ((cmd_op == OP_UP && all_nine) || (cmd_op == OP_DOWN && all_zero)) begin
                                done_nx = 1'b1;
                                wrap_nx = 1'b1;
                            end else
`endif
                            begin
                                state_nx  = STEP;
                                idx_nx    = '0;
                                dir_up_nx = (cmd_op == OP_UP);
                            end
                        end
                    endcase
                end
            end
            STEP: begin
                cnt_nx[{idx, 2'b00} +: 4] = new_digit;
                if (!carry || idx == LAST) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    done_nx  = 1'b1;
                    wrap_nx  = carry;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt_q  <= '0;
            idx    <= '0;
            dir_up <= 1'b0;
            done   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt_q  <= cnt_nx;
            idx    <= idx_nx;
            dir_up <= dir_up_nx;
            done   <= done_nx;
            wrap   <= wrap_nx;
        end
    end

    assign count     = cnt_q;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == STEP);
endmodule
